probe_access_arb: RTL and testbench

PROBE_ACCESS_ARB -- requirements
Module: probe_access_arb

---
 rtl/probe_access_pkg.sv | 38 +++
 rtl/probe_rr_arbiter.sv | 51 +++++
 rtl/probe_access_arb.sv | 332 +++++++++++++++++++++++++++++++++
 tb/tb_probe_access_arb.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/probe_access_pkg.sv
// -----------------------------------------------------------------------------
// probe_access_pkg
// Shared types and constants for the probe access arbiter:
//   op_e     - request opcode (GET/PUT/FIRST/NEXT)
//   state_e  - control FSM state (IDLE/EXEC/RESP)
//   CNT_W    - width of the optional per-requester grant counters
//   sat_inc  - saturating increment helper for those counters
// -----------------------------------------------------------------------------
package probe_access_pkg;

  typedef enum logic [1:0] {
    OP_GET   = 2'd0,
    OP_PUT   = 2'd1,
    OP_FIRST = 2'd2,
    OP_NEXT  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] res;
    if (cnt == CNT_MAX) begin
      res = CNT_MAX;
    end else begin
      res = cnt + 16'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/probe_rr_arbiter.sv
// -----------------------------------------------------------------------------
// probe_rr_arbiter
// Purely combinational round-robin arbiter. The search starts one position
// after last_grant and wraps, so the most recently served requester has the
// lowest priority.
// Ports:
//   req        in   NUM_REQ          request vector
//   last_grant in   $clog2(NUM_REQ)  index of the previous winner
//   grant      out  NUM_REQ          one-hot winner (all zero when no request)
// -----------------------------------------------------------------------------
module probe_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         grant
);

  // Distance of requester j from the search start (last_grant+1) going
  // upward with wrap; distances are unique, so the minimum is one-hot.
  function automatic int rr_dist(input int j, input int last);
    return (j + NUM_REQ - last - 1) % NUM_REQ;
  endfunction

  int best_dist_s;

  // Find the smallest search distance among active requesters.
  always_comb begin
    best_dist_s = NUM_REQ;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (req[j] && (rr_dist(j, int'(last_grant)) < best_dist_s)) begin
        best_dist_s = rr_dist(j, int'(last_grant));
      end else begin
        best_dist_s = best_dist_s;
      end
    end
  end

  // Grant the requester sitting at that distance.
  always_comb begin
    grant = {NUM_REQ{1'b0}};
    for (int j = 0; j < NUM_REQ; j++) begin
      if (req[j] && (rr_dist(j, int'(last_grant)) == best_dist_s)) begin
        grant[j] = 1'b1;
      end else begin
        grant[j] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/probe_access_arb.sv
// -----------------------------------------------------------------------------
// probe_access_arb
// Arbitrated access to a small table of probe entries (value + valid bit) with
// a per-requester scan cursor. One request is served at a time through an
// IDLE -> EXEC -> RESP sequence; the response is registered and held until
// rsp_ready.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   per-requester handshake (ready only in IDLE, one-hot)
//   req_op            2 bits per requester: GET/PUT/FIRST/NEXT
//   req_handle        entry index per requester
//   req_wdata         PUT value per requester
//   rsp_valid/ready   response handshake
//   rsp_id            requester being answered
//   rsp_handle        entry answered
//   rsp_data          entry value (0 when null)
//   rsp_null          no valid entry
//   grant_cnt         (PROBE_ACCESS_ARB_STATS_EN only) 16-bit saturating
//                     accept counter per requester
// Optional feature macro: PROBE_ACCESS_ARB_STATS_EN
// -----------------------------------------------------------------------------
module probe_access_arb
  import probe_access_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int NUM_ENTRIES = 16,
  parameter int DATA_W      = 32
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_REQ-1:0]                     req_valid,
  output logic [NUM_REQ-1:0]                     req_ready,
  input  logic [NUM_REQ*2-1:0]                   req_op,
  input  logic [NUM_REQ*$clog2(NUM_ENTRIES)-1:0] req_handle,
  input  logic [NUM_REQ*DATA_W-1:0]              req_wdata,
  output logic                                   rsp_valid,
  input  logic                                   rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]             rsp_id,
  output logic [$clog2(NUM_ENTRIES)-1:0]         rsp_handle,
  output logic [DATA_W-1:0]                      rsp_data,
  output logic                                   rsp_null
`ifdef PROBE_ACCESS_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0]               grant_cnt
`endif
);

  localparam int H_W  = $clog2(NUM_ENTRIES);
  localparam int ID_W = $clog2(NUM_REQ);

  state_e              state_r;
  state_e              state_nxt_s;
  logic                accept_s;

  logic [ID_W-1:0]     last_grant_r;
  logic [NUM_REQ-1:0]  grant_s;
  logic [ID_W-1:0]     grant_id_s;
  logic [1:0]          sel_op_s;
  logic [H_W-1:0]      sel_handle_s;
  logic [DATA_W-1:0]   sel_wdata_s;

  logic [ID_W-1:0]     acc_id_r;
  op_e                 acc_op_r;
  logic [H_W-1:0]      acc_handle_r;
  logic [DATA_W-1:0]   acc_wdata_r;

  logic [DATA_W-1:0]   value_r [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] valid_r;
  logic [H_W-1:0]      cursor_r [NUM_REQ];
  logic [H_W-1:0]      cur_s;

  logic                first_found_s;
  logic [H_W-1:0]      first_idx_s;
  logic                next_found_s;
  logic [H_W-1:0]      next_idx_s;

  logic [DATA_W-1:0]   res_data_s;
  logic                res_null_s;
  logic [H_W-1:0]      res_handle_s;
  logic                put_en_s;
  logic                cur_upd_s;
  logic [H_W-1:0]      cur_val_s;

  logic                rsp_valid_r;
  logic [ID_W-1:0]     rsp_id_r;
  logic [H_W-1:0]      rsp_handle_r;
  logic [DATA_W-1:0]   rsp_data_r;
  logic                rsp_null_r;

  probe_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_r),
    .grant      (grant_s)
  );

  // Decode the one-hot grant into an index and mux the winner's fields.
  always_comb begin
    grant_id_s   = {ID_W{1'b0}};
    sel_op_s     = 2'b00;
    sel_handle_s = {H_W{1'b0}};
    sel_wdata_s  = {DATA_W{1'b0}};
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant_s[j]) begin
        grant_id_s   = ID_W'(j);
        sel_op_s     = req_op[j*2 +: 2];
        sel_handle_s = req_handle[j*H_W +: H_W];
        sel_wdata_s  = req_wdata[j*DATA_W +: DATA_W];
      end else begin
        grant_id_s = grant_id_s;
      end
    end
  end

  // Control FSM next state; a request is accepted on any IDLE cycle with a valid.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (|req_valid) begin
          state_nxt_s = ST_EXEC;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: state_nxt_s = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Ready is only offered to the arbitration winner while idle.
  always_comb begin
    if (state_r == ST_IDLE) begin
      req_ready = grant_s;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Capture the accepted request and remember the winner for round-robin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= ID_W'(NUM_REQ - 1);
      acc_id_r     <= {ID_W{1'b0}};
      acc_op_r     <= OP_GET;
      acc_handle_r <= {H_W{1'b0}};
      acc_wdata_r  <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      last_grant_r <= grant_id_s;
      acc_id_r     <= grant_id_s;
      acc_op_r     <= op_e'(sel_op_s);
      acc_handle_r <= sel_handle_s;
      acc_wdata_r  <= sel_wdata_s;
    end
  end

  assign cur_s = cursor_r[acc_id_r];

  // Scan for the lowest valid entry overall and the lowest one above the
  // cursor; iterating downward leaves the lowest hit in the result.
  always_comb begin
    first_found_s = 1'b0;
    first_idx_s   = {H_W{1'b0}};
    next_found_s  = 1'b0;
    next_idx_s    = {H_W{1'b0}};
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (valid_r[i]) begin
        first_found_s = 1'b1;
        first_idx_s   = H_W'(i);
      end else begin
        first_found_s = first_found_s;
      end
      if (valid_r[i] && (H_W'(i) > cur_s)) begin
        next_found_s = 1'b1;
        next_idx_s   = H_W'(i);
      end else begin
        next_found_s = next_found_s;
      end
    end
  end

  // Operation result computed from the latched request during EXEC.
  always_comb begin
    res_data_s   = {DATA_W{1'b0}};
    res_null_s   = 1'b1;
    res_handle_s = {H_W{1'b0}};
    put_en_s     = 1'b0;
    cur_upd_s    = 1'b0;
    cur_val_s    = cur_s;
    case (acc_op_r)
      OP_GET: begin
        res_handle_s = acc_handle_r;
        res_null_s   = ~valid_r[acc_handle_r];
        if (valid_r[acc_handle_r]) begin
          res_data_s = value_r[acc_handle_r];
        end else begin
          res_data_s = {DATA_W{1'b0}};
        end
      end
      OP_PUT: begin
        res_handle_s = acc_handle_r;
        res_null_s   = 1'b0;
        res_data_s   = acc_wdata_r;
        put_en_s     = 1'b1;
      end
      OP_FIRST: begin
        // FIRST always repositions the cursor, to 0 when the table is empty.
        cur_upd_s = 1'b1;
        if (first_found_s) begin
          res_handle_s = first_idx_s;
          res_null_s   = 1'b0;
          res_data_s   = value_r[first_idx_s];
          cur_val_s    = first_idx_s;
        end else begin
          cur_val_s = {H_W{1'b0}};
        end
      end
      OP_NEXT: begin
        // No wrap: a miss leaves the cursor where it was.
        if (next_found_s) begin
          res_handle_s = next_idx_s;
          res_null_s   = 1'b0;
          res_data_s   = value_r[next_idx_s];
          cur_upd_s    = 1'b1;
          cur_val_s    = next_idx_s;
        end else begin
          cur_upd_s = 1'b0;
        end
      end
      default: begin
        res_null_s = 1'b1;
      end
    endcase
  end

  // Entry table: PUT writes the value and marks the entry valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= {NUM_ENTRIES{1'b0}};
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        value_r[i] <= {DATA_W{1'b0}};
      end
    end else if ((state_r == ST_EXEC) && put_en_s) begin
      valid_r[acc_handle_r] <= 1'b1;
      value_r[acc_handle_r] <= acc_wdata_r;
    end
  end

  // Per-requester scan cursors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        cursor_r[r] <= {H_W{1'b0}};
      end
    end else if ((state_r == ST_EXEC) && cur_upd_s) begin
      cursor_r[acc_id_r] <= cur_val_s;
    end
  end

  // Registered response: loaded at the end of EXEC, held until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= {ID_W{1'b0}};
      rsp_handle_r <= {H_W{1'b0}};
      rsp_data_r   <= {DATA_W{1'b0}};
      rsp_null_r   <= 1'b0;
    end else if (state_r == ST_EXEC) begin
      rsp_valid_r  <= 1'b1;
      rsp_id_r     <= acc_id_r;
      rsp_handle_r <= res_handle_s;
      rsp_data_r   <= res_data_s;
      rsp_null_r   <= res_null_s;
    end else if ((state_r == ST_RESP) && rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end
  end

  assign rsp_valid  = rsp_valid_r;
  assign rsp_id     = rsp_id_r;
  assign rsp_handle = rsp_handle_r;
  assign rsp_data   = rsp_data_r;
  assign rsp_null   = rsp_null_r;

`ifdef PROBE_ACCESS_ARB_STATS_EN
  logic [CNT_W-1:0] grant_cnt_r [NUM_REQ];

  // Saturating accept counters, one per requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        grant_cnt_r[r] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (accept_s && grant_s[r]) begin
          grant_cnt_r[r] <= sat_inc(grant_cnt_r[r]);
        end
      end
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    grant_cnt = {(NUM_REQ*CNT_W){1'b0}};
    for (int r = 0; r < NUM_REQ; r++) begin
      grant_cnt[r*CNT_W +: CNT_W] = grant_cnt_r[r];
    end
  end
`else
`endif

endmodule

// File: tb/tb_probe_access_arb.sv
// -----------------------------------------------------------------------------
// tb_probe_access_arb
// Directed self-checking bench for probe_access_arb (NUM_REQ=2,
// NUM_ENTRIES=16, DATA_W=32). Grant counter checks are included when
// PROBE_ACCESS_ARB_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_probe_access_arb;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_op;
  logic [7:0]  req_handle;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [3:0]  rsp_handle;
  logic [31:0] rsp_data;
  logic        rsp_null;
`ifdef PROBE_ACCESS_ARB_STATS_EN
  logic [31:0] grant_cnt;
`endif

  int errors;
  int checks;

  probe_access_arb #(
    .NUM_REQ     (2),
    .NUM_ENTRIES (16),
    .DATA_W      (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_handle (req_handle),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_handle (rsp_handle),
    .rsp_data   (rsp_data),
    .rsp_null   (rsp_null)
`ifdef PROBE_ACCESS_ARB_STATS_EN
    ,
    .grant_cnt  (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [1:0] op, input logic [3:0] h,
                         input logic [31:0] d);
    req_op[id*2 +: 2]      = op;
    req_handle[id*4 +: 4]  = h;
    req_wdata[id*32 +: 32] = d;
  endtask

  // One complete transaction from a single requester, checking latency and fields.
  task automatic xact(input string tag, input int id, input logic [1:0] op,
                      input logic [3:0] h, input logic [31:0] d,
                      input logic exp_null, input logic [3:0] exp_h,
                      input logic [31:0] exp_d);
    int n;
    @(negedge clk);
    set_req(id, op, h, d);
    req_valid[id] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[id] && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_ready"}, {31'd0, req_ready[id]}, 32'd1);
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
    @(negedge clk);
    check({tag, "_exec_valid"}, {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, "_id"}, {31'd0, rsp_id}, id);
    check({tag, "_null"}, {31'd0, rsp_null}, {31'd0, exp_null});
    check({tag, "_handle"}, {28'd0, rsp_handle}, {28'd0, exp_h});
    check({tag, "_data"}, rsp_data, exp_d);
  endtask

  initial begin
    int n;
    errors     = 0;
    checks     = 0;
    rst_n      = 1'b0;
    rsp_ready  = 1'b1;
    req_valid  = 2'b00;
    req_op     = 4'd0;
    req_handle = 8'd0;
    req_wdata  = 64'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_null", {31'd0, rsp_null}, 32'd0);
    check("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    check("rst_rsp_handle", {28'd0, rsp_handle}, 32'd0);
    check("rst_req_ready", {30'd0, req_ready}, 32'd0);
    rst_n = 1'b1;

    // GET of an empty entry
    xact("get_h5_empty", 0, 2'd0, 4'd5, 32'd0, 1'b1, 4'd5, 32'd0);
    // PUT then cross-requester GET
    xact("put_h3", 0, 2'd1, 4'd3, 32'h0000_00AA, 1'b0, 4'd3, 32'h0000_00AA);
    xact("get_h3_req1", 1, 2'd0, 4'd3, 32'd0, 1'b0, 4'd3, 32'h0000_00AA);

    // Reset while a PUT h9 is in EXEC
    @(negedge clk);
    set_req(0, 2'd1, 4'd9, 32'h0000_0099);
    req_valid[0] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[0] && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("rstx_ready", {31'd0, req_ready[0]}, 32'd1);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstx_in_reset_valid", {31'd0, rsp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rstx_after_valid", {31'd0, rsp_valid}, 32'd0);
    end

    // First contention after reset: requester 0 wins, then requester 1
    set_req(0, 2'd0, 4'd9, 32'd0);
    set_req(1, 2'd0, 4'd9, 32'd0);
    req_valid = 2'b11;
    #1;
    check("post_rst_grant0", {30'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_get_h9_id", {31'd0, rsp_id}, 32'd0);
    check("post_rst_get_h9_null", {31'd0, rsp_null}, 32'd1);
    check("post_rst_get_h9_data", rsp_data, 32'd0);
    @(negedge clk);
    #1;
    check("post_rst_grant1", {30'd0, req_ready}, 32'd2);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_get1_id", {31'd0, rsp_id}, 32'd1);
    check("post_rst_get1_null", {31'd0, rsp_null}, 32'd1);

    // Scans: empty FIRST, then entries {2,7,12}
    xact("first_empty", 0, 2'd2, 4'd0, 32'd0, 1'b1, 4'd0, 32'd0);
    xact("put_h2", 0, 2'd1, 4'd2, 32'h0000_0022, 1'b0, 4'd2, 32'h0000_0022);
    xact("put_h7", 0, 2'd1, 4'd7, 32'h0000_0077, 1'b0, 4'd7, 32'h0000_0077);
    xact("put_h12", 0, 2'd1, 4'd12, 32'h0000_00CC, 1'b0, 4'd12, 32'h0000_00CC);
    xact("first", 1, 2'd2, 4'd0, 32'd0, 1'b0, 4'd2, 32'h0000_0022);
    xact("next1", 1, 2'd3, 4'd0, 32'd0, 1'b0, 4'd7, 32'h0000_0077);
    xact("next2", 1, 2'd3, 4'd0, 32'd0, 1'b0, 4'd12, 32'h0000_00CC);
    xact("next3_end", 1, 2'd3, 4'd0, 32'd0, 1'b1, 4'd0, 32'd0);
    // Cursor must still be 12: a new entry 13 is the next hit, not entry 2
    xact("put_h13", 0, 2'd1, 4'd13, 32'h0000_00DD, 1'b0, 4'd13, 32'h0000_00DD);
    xact("next_after_end", 1, 2'd3, 4'd0, 32'd0, 1'b0, 4'd13, 32'h0000_00DD);

    // Continuous contention: grants alternate 0,1,0,1; first response stalls
    @(negedge clk);
    set_req(0, 2'd0, 4'd2, 32'd0);
    set_req(1, 2'd0, 4'd2, 32'd0);
    req_valid = 2'b11;
    for (int t = 0; t < 4; t++) begin
      #1;
      n = 0;
      while (req_ready == 2'b00 && n < 20) begin
        @(negedge clk);
        #1;
        n++;
      end
      check("cont_grant", {30'd0, req_ready}, (t % 2 == 0) ? 32'd1 : 32'd2);
      @(posedge clk);
      if (t == 3) begin
        #1;
        req_valid = 2'b00;
      end
      @(negedge clk);
      check("cont_exec_ready", {30'd0, req_ready}, 32'd0);
      @(negedge clk);
      check("cont_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("cont_rsp_id", {31'd0, rsp_id}, t % 2);
      check("cont_rsp_data", rsp_data, 32'h0000_0022);
      if (t == 0) begin
        rsp_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          check("stall_valid", {31'd0, rsp_valid}, 32'd1);
          check("stall_id", {31'd0, rsp_id}, 32'd0);
          check("stall_handle", {28'd0, rsp_handle}, 32'd2);
          check("stall_data", rsp_data, 32'h0000_0022);
          check("stall_null", {31'd0, rsp_null}, 32'd0);
          check("stall_ready", {30'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
      end
      @(negedge clk);
    end

`ifdef PROBE_ACCESS_ARB_STATS_EN
    // Saturation of the accept counter from a fresh reset
    rst_n = 1'b0;
    @(negedge clk);
    check("stats_rst0", {16'd0, grant_cnt[15:0]}, 32'd0);
    rst_n = 1'b1;
    set_req(0, 2'd0, 4'd0, 32'd0);
    req_valid = 2'b01;
    repeat (70000 * 3 + 10) @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    repeat (4) @(negedge clk);
    check("stats_cnt0_sat", {16'd0, grant_cnt[15:0]}, 32'h0000_FFFF);
    check("stats_cnt1_zero", {16'd0, grant_cnt[31:16]}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
